// File: rtl/shift_serializer_if.sv
// Handshake and serial-link signals between a word source, the serializer and
// the 4-bit bidirectional shift register it feeds.
interface shift_serializer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic             dir;
  logic             stall;
  logic             serout;
  logic             modeout;
  logic             shiften;
  logic             ready;
  logic             busy;
  logic             done;

  modport master (
    output load, data, dir, stall,
    input  serout, modeout, shiften, ready, busy, done
  );

  modport slave (
    input  load, data, dir, stall,
    output serout, modeout, shiften, ready, busy, done
  );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-in, serial-out transmitter: sends a WIDTH-bit word one bit per clock,
// ordered so the downstream shift register ends with out1..outN = data[WIDTH-1..0].
module shift_serializer #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input logic            clk,
  input logic            rst_n,
  shift_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             ser_q;
  logic             mode_q;
  logic             accept;
  logic             advance;
  logic             last;

  assign accept  = (state == IDLE) && bus.load;
  assign advance = (state == SHIFT) && !bus.stall;
  assign last    = advance && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last)   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The first bit is pulled out at the accepting edge, so shreg only ever holds
  // the bits still to be sent and ser_q is valid in the very next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      cnt    <= '0;
      ser_q  <= 1'b0;
      mode_q <= 1'b0;
    end else if (accept) begin
      mode_q <= bus.dir;
      cnt    <= CW'(WIDTH - 1);
      if (bus.dir) begin
        ser_q <= bus.data[0];
        shreg <= bus.data >> 1;
      end else begin
        ser_q <= bus.data[WIDTH-1];
        shreg <= bus.data << 1;
      end
    end else if (last) begin
      ser_q <= 1'b0;
    end else if (advance) begin
      cnt <= cnt - 1'b1;
      if (mode_q) begin
        ser_q <= shreg[0];
        shreg <= shreg >> 1;
      end else begin
        ser_q <= shreg[WIDTH-1];
        shreg <= shreg << 1;
      end
    end
  end

  assign bus.serout  = ser_q;
  assign bus.modeout = mode_q;
  assign bus.shiften = advance;
  assign bus.ready   = (state == IDLE);
  assign bus.busy    = (state == SHIFT);
  assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer: drives words through the serializer into
// a model of the 4-bit bidirectional receiver and checks the serial stream.
module tb_shift_serializer;

  logic clk;
  logic rst_n;
  int   nCompared   = 0;
  int   nMismatched = 0;
  int   doneCount   = 0;
  int   base;
  logic [3:0]  rx = 4'b0000;
  logic [1:12] expBusy;
  logic [1:12] expDone;
  logic [1:12] expSer;

  shift_serializer_if #(.WIDTH(4)) bus ();

  shift_serializer #(.WIDTH(4), .CW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver model: rx[3] is out1, rx[0] is out4; clocked only when shiften is high.
  always @(posedge clk) begin
    if (bus.shiften === 1'b1) begin
      if (bus.modeout) rx <= {bus.serout, rx[3:1]};
      else             rx <= {rx[2:0], bus.serout};
    end
  end

  always @(posedge clk) begin
    if (bus.done === 1'b1) doneCount <= doneCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [3:0] d, input logic dr, input logic st);
    bus.load  = ld;
    bus.data  = d;
    bus.dir   = dr;
    bus.stall = st;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // seq lists the expected serial bits, first-sent bit in seq[3].
  task automatic runWord(input string name, input logic [3:0] d, input logic dr, input logic [3:0] seq);
    applyStimulus(1'b1, d, dr, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput({name, "_ser"}, 32'(bus.serout), 32'(seq[3-i]));
      checkOutput({name, "_shiften"}, 32'(bus.shiften), 32'd1);
      checkOutput({name, "_modeout"}, 32'(bus.modeout), 32'(dr));
      nextCycle();
    end
    checkOutput({name, "_done"}, 32'(bus.done), 32'd1);
    checkOutput({name, "_busy_done"}, 32'(bus.busy), 32'd0);
    checkOutput({name, "_ready_done"}, 32'(bus.ready), 32'd0);
    checkOutput({name, "_ser_done"}, 32'(bus.serout), 32'd0);
    nextCycle();
    checkOutput({name, "_ready_idle"}, 32'(bus.ready), 32'd1);
    checkOutput({name, "_done_idle"}, 32'(bus.done), 32'd0);
    checkOutput({name, "_rx"}, 32'(rx), 32'(d));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(bus.ready), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_ser", 32'(bus.serout), 32'd0);
    checkOutput("rst_shiften", 32'(bus.shiften), 32'd0);
    checkOutput("rst_modeout", 32'(bus.modeout), 32'd0);
    rst_n = 1'b1;
    nextCycle();

    // Right mode 1011: LSB first gives 1,1,0,1
    runWord("right", 4'b1011, 1'b1, 4'b1101);
    checkOutput("right_modeout_idle", 32'(bus.modeout), 32'd1);

    // Left mode 1001: MSB first gives 1,0,0,1
    runWord("left", 4'b1001, 1'b0, 4'b1001);
    checkOutput("left_modeout_idle", 32'(bus.modeout), 32'd0);

    // Stall in cycles k+2 and k+3 on word 0110, right mode
    base = doneCount;
    applyStimulus(1'b1, 4'b0110, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("stall_ser1", 32'(bus.serout), 32'd0);
    checkOutput("stall_en1", 32'(bus.shiften), 32'd1);
    nextCycle();
    bus.stall = 1'b1;
    #1;
    checkOutput("stall_ser2", 32'(bus.serout), 32'd1);
    checkOutput("stall_en2", 32'(bus.shiften), 32'd0);
    checkOutput("stall_busy2", 32'(bus.busy), 32'd1);
    nextCycle();
    checkOutput("stall_ser3", 32'(bus.serout), 32'd1);
    checkOutput("stall_en3", 32'(bus.shiften), 32'd0);
    nextCycle();
    bus.stall = 1'b0;
    #1;
    checkOutput("stall_ser4", 32'(bus.serout), 32'd1);
    checkOutput("stall_en4", 32'(bus.shiften), 32'd1);
    nextCycle();
    checkOutput("stall_ser5", 32'(bus.serout), 32'd1);
    nextCycle();
    checkOutput("stall_ser6", 32'(bus.serout), 32'd0);
    checkOutput("stall_done6", 32'(bus.done), 32'd0);
    nextCycle();
    checkOutput("stall_done7", 32'(bus.done), 32'd1);
    nextCycle();
    checkOutput("stall_rx", 32'(rx), 32'(4'b0110));
    checkOutput("stall_done_pulses", 32'(doneCount - base), 32'd1);

    // Load held through SHIFT and DONE with 4'hF must not disturb word 0011 (left)
    base = doneCount;
    applyStimulus(1'b1, 4'b0011, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
    checkOutput("ign_ser1", 32'(bus.serout), 32'd0);
    nextCycle();
    checkOutput("ign_ser2", 32'(bus.serout), 32'd0);
    nextCycle();
    checkOutput("ign_ser3", 32'(bus.serout), 32'd1);
    nextCycle();
    checkOutput("ign_ser4", 32'(bus.serout), 32'd1);
    checkOutput("ign_modeout4", 32'(bus.modeout), 32'd0);
    nextCycle();
    checkOutput("ign_done5", 32'(bus.done), 32'd1);
    checkOutput("ign_ready5", 32'(bus.ready), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("ign_ready6", 32'(bus.ready), 32'd1);
    checkOutput("ign_rx", 32'(rx), 32'(4'b0011));
    nextCycle();
    checkOutput("ign_busy7", 32'(bus.busy), 32'd0);
    checkOutput("ign_ready7", 32'(bus.ready), 32'd1);
    checkOutput("ign_modeout7", 32'(bus.modeout), 32'd0);
    checkOutput("ign_done_pulses", 32'(doneCount - base), 32'd1);

    // Back-to-back with load held: A at edge k, 5 at edge k+6
    base    = doneCount;
    expBusy = 12'b111100111100;
    expDone = 12'b000010000010;
    expSer  = 12'b010100101000;
    applyStimulus(1'b1, 4'hA, 1'b1, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      nextCycle();
      checkOutput($sformatf("b2b_busy_c%0d", c), 32'(bus.busy), 32'(expBusy[c]));
      checkOutput($sformatf("b2b_done_c%0d", c), 32'(bus.done), 32'(expDone[c]));
      checkOutput($sformatf("b2b_ser_c%0d", c), 32'(bus.serout), 32'(expSer[c]));
      if (c == 1) bus.data = 4'h5;
      if (c == 7) bus.load = 1'b0;
    end
    checkOutput("b2b_rx", 32'(rx), 32'h5);
    checkOutput("b2b_done_pulses", 32'(doneCount - base), 32'd2);

    // Asynchronous reset in the middle of a word
    applyStimulus(1'b1, 4'hF, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("abort_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(bus.ready), 32'd1);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_ser", 32'(bus.serout), 32'd0);
    checkOutput("abort_shiften", 32'(bus.shiften), 32'd0);
    checkOutput("abort_modeout", 32'(bus.modeout), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    base = doneCount;
    nextCycle();
    rst_n = 1'b1;
    repeat (6) nextCycle();
    checkOutput("abort_ready_after", 32'(bus.ready), 32'd1);
    checkOutput("abort_no_done", 32'(doneCount - base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/shift_serializer.md
Name: shift_serializer

Overview:
- Parallel-in, serial-out transmitter that feeds the 4-bit bidirectional shift register (serial inputs ShiftRight/ShiftLeft, Mode select).
- Accepts a WIDTH-bit word with a load handshake and emits one bit per clock on SerOut, together with the matching ModeOut.
- Bit order is chosen so the receiving register ends with out1 = Data[WIDTH-1] … outN = Data[0] for either direction.
- Clock gating on the receiver side uses ShiftEn.

Parameters:
- WIDTH, 4, word length in bits; also the number of shift cycles per word; must be ≥ 2.
- CW, 3, counter width; must satisfy 2^CW > WIDTH.

Ports:
- CLK      input   1      system clock; all state changes on the rising edge.
- CLR      input   1      reset, asynchronous, active-low.
- Load     input   1      request to transmit Data; accepted only when Load && Ready at a rising edge.
- Data     input   WIDTH  parallel word; sampled on an accepted Load.
- Dir      input   1      1 = right mode (LSB sent first); 0 = left mode (MSB sent first); sampled on an accepted Load.
- Stall    input   1      freezes shifting while high.
- SerOut   output  1      serial data bit; drive to the receiver's ShiftRight (Dir=1) or ShiftLeft (Dir=0).
- ModeOut  output  1      registered copy of the captured Dir; drive to the receiver's Mode.
- ShiftEn  output  1      high in every cycle in which SerOut carries a valid bit to be shifted in.
- Ready    output  1      high only in IDLE.
- Busy     output  1      high in SHIFT.
- Done     output  1      one-cycle pulse after the last bit.

Behaviour:
- Reset (CLR=0, asynchronous):
  - state = IDLE; shift register, counter and ModeOut cleared to 0.
  - SerOut = 0, ShiftEn = 0, Busy = 0, Done = 0, Ready = 1.
  - Takes effect immediately, including mid-word; the partial word is discarded with no Done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT on Load && Ready:
  - Capture Data into the shift register and Dir into ModeOut.
  - Counter = WIDTH − 1.
  - Load while not in IDLE is ignored: no queueing and no effect on the current word.
- SHIFT:
  - SerOut = Data[0] shifted rightward when ModeOut = 1; SerOut = Data[WIDTH-1] shifted leftward when ModeOut = 0. SerOut is registered; the first bit appears in the cycle immediately after the accepting edge.
  - ShiftEn = !Stall. Busy = 1.
  - Each edge with Stall = 0 advances one bit and decrements the counter.
  - When Stall = 1, shift register, counter, SerOut and ModeOut hold.
  - After the edge that consumes the last bit (counter = 0, Stall = 0), go to DONE.
- DONE:
  - Done = 1, Busy = 0, Ready = 0, ShiftEn = 0. SerOut returns to 0.
  - Next edge goes to IDLE unconditionally; Load in this cycle is ignored.
- Latency: with no stalls, Load is accepted at edge k, bits are valid in cycles k+1 … k+WIDTH, Done is high in cycle k+WIDTH+1, and Ready rises in cycle k+WIDTH+2. Each stalled cycle adds exactly one cycle.
- Throughput: one word per WIDTH+2 cycles.
- ModeOut is stable for the whole word, so the receiver Mode never changes mid-word. ModeOut keeps its last value in IDLE and DONE.
- Receiver result after a word, given the receiver is clocked only when ShiftEn = 1: out1..outN = Data[WIDTH-1..0] for both Dir values.
- Stall in IDLE or DONE has no effect.
- Simultaneous CLR = 0 and Load: reset wins.

Test Plan:
- Reset: CLR=0 mid-SHIFT → all outputs 0, Ready=1 immediately without waiting for a clock edge; after release, Ready stays 1 and Done never pulses for the aborted word.
- Right mode: Load=1, Data=4'b1011, Dir=1 → SerOut = 1,1,0,1 in cycles k+1..k+4 with ShiftEn=1 and ModeOut=1; Done high in cycle k+5; receiver ends with out1..out4 = 1,0,1,1.
- Left mode: Data=4'b1001, Dir=0 → SerOut = 1,0,0,1 with ModeOut=0; receiver ends with out1..out4 = 1,0,0,1.
- Stall: Data=4'b0110, Dir=1, Stall=1 during cycles k+2 and k+3 → SerOut holds at 1 with ShiftEn=0 in both stalled cycles; sequence completes as 0,1,1,0; Done in cycle k+7.
- Ignored Load: second Load with Data=4'hF during SHIFT and again in DONE → first word transmitted unchanged; exactly one Done pulse; Ready returns to 1 with no second word sent.
- Back-to-back: Load held high continuously with 4'hA then 4'h5, Dir=1 → words start at edges k and k+6; no overlap; two Done pulses spaced 6 cycles apart.
